// File: rtl/sap_ctrl_seq.sv
// sap_ctrl_seq: controller-sequencer for the 8-bit bus datapath.
// Runs a six-state ring counter (T1..T6) and decodes the IR opcode into the
// control word that gates every register's bus drive and load.
// Optional single-step mode is enabled by defining SAP_CTRL_STEP_EN, which
// adds a `step` input; without it the ring advances every clock.
module sap_ctrl_seq #(
   parameter int unsigned OPW = 4,
   parameter int unsigned NT  = 6
) (
   input  logic           clk,
   input  logic           clr,
   input  logic           run,
`ifdef SAP_CTRL_STEP_EN
   input  logic           step,
`endif
   input  logic [OPW-1:0] ir_op,
   output logic           cp,
   output logic           ep,
   output logic           lm_n,
   output logic           ce_n,
   output logic           li_n,
   output logic           ei,
   output logic           la_n,
   output logic           ea,
   output logic           su,
   output logic           eu,
   output logic           lb_n,
   output logic           lo_n,
   output logic [NT-1:0]  tstate,
   output logic           halted
);

   localparam logic [OPW-1:0] OpLda = OPW'(0);
   localparam logic [OPW-1:0] OpAdd = OPW'(1);
   localparam logic [OPW-1:0] OpSub = OPW'(2);
   localparam logic [OPW-1:0] OpOut = OPW'(14);
   localparam logic [OPW-1:0] OpHlt = OPW'(15);

   typedef enum logic [2:0] {
      StIdle,
      StT1,
      StT2,
      StT3,
      StT4,
      StT5,
      StT6,
      StHalt
   } state_e;

   state_e state;
   logic   adv;

`ifdef SAP_CTRL_STEP_EN
   logic step_s1;
   logic step_s2;
   logic step_dly;

   // Two-flop synchronizer plus delay flop for rising-edge detection of step
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         step_s1  <= 1'b0;
         step_s2  <= 1'b0;
         step_dly <= 1'b0;
      end else begin
         step_s1  <= step;
         step_s2  <= step_s1;
         step_dly <= step_s2;
      end
   end

   assign adv = step_s2 & ~step_dly;
`else
   assign adv = 1'b1;
`endif

   // Sequencer state: IDLE waits for run, ring T1..T6, HLT parks in HALT until clr
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state <= StIdle;
      end else begin
         unique case (state)
            StIdle:  if (run && adv) state <= StT1;
            StT1:    if (adv) state <= StT2;
            StT2:    if (adv) state <= StT3;
            StT3:    if (adv) state <= StT4;
            StT4:    if (adv) state <= (ir_op == OpHlt) ? StHalt : StT5;
            StT5:    if (adv) state <= StT6;
            StT6:    if (adv) state <= StT1;
            StHalt:  state <= StHalt;
            default: state <= StIdle;
         endcase
      end
   end

   // One-hot T-state view; IDLE and HALT show all zero
   always_comb begin
      tstate = '0;
      unique case (state)
         StT1:    tstate[0] = 1'b1;
         StT2:    tstate[1] = 1'b1;
         StT3:    tstate[2] = 1'b1;
         StT4:    tstate[3] = 1'b1;
         StT5:    tstate[4] = 1'b1;
         StT6:    tstate[5] = 1'b1;
         default: tstate = '0;
      endcase
   end

   assign halted = (state == StHalt);

   // Control-word decode; ir_op is only consulted in T4..T6 so fetch is opcode-blind
   always_comb begin
      cp   = 1'b0;
      ep   = 1'b0;
      lm_n = 1'b1;
      ce_n = 1'b1;
      li_n = 1'b1;
      ei   = 1'b0;
      la_n = 1'b1;
      ea   = 1'b0;
      su   = 1'b0;
      eu   = 1'b0;
      lb_n = 1'b1;
      lo_n = 1'b1;
      unique case (state)
         StT1: begin
            ep   = 1'b1;
            lm_n = 1'b0;
         end
         StT2: begin
            cp = 1'b1;
         end
         StT3: begin
            ce_n = 1'b0;
            li_n = 1'b0;
         end
         StT4: begin
            if (ir_op == OpLda || ir_op == OpAdd || ir_op == OpSub) begin
               ei   = 1'b1;
               lm_n = 1'b0;
            end else if (ir_op == OpOut) begin
               ea   = 1'b1;
               lo_n = 1'b0;
            end
         end
         StT5: begin
            if (ir_op == OpLda) begin
               ce_n = 1'b0;
               la_n = 1'b0;
            end else if (ir_op == OpAdd || ir_op == OpSub) begin
               ce_n = 1'b0;
               lb_n = 1'b0;
               su   = (ir_op == OpSub);
            end
         end
         StT6: begin
            if (ir_op == OpAdd || ir_op == OpSub) begin
               eu   = 1'b1;
               la_n = 1'b0;
               su   = (ir_op == OpSub);
            end
         end
         default: begin
            cp = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_sap_ctrl_seq.sv
// Directed bench for sap_ctrl_seq (default build, SAP_CTRL_STEP_EN undefined).
module tb_sap_ctrl_seq;

   logic       clk;
   logic       clr;
   logic       run;
   logic [3:0] ir_op;
   logic       cp, ep, lm_n, ce_n, li_n, ei, la_n, ea, su, eu, lb_n, lo_n;
   logic [5:0] tstate;
   logic       halted;

   int checks = 0;
   int errors = 0;

   // Control word packed as {cp,ep,lm_n,ce_n,li_n,ei,la_n,ea,su,eu,lb_n,lo_n}
   localparam logic [11:0] INACT = 12'h3A3;
   localparam logic [11:0] CP = 12'h800;
   localparam logic [11:0] EP = 12'h400;
   localparam logic [11:0] LM = 12'h200;
   localparam logic [11:0] CE = 12'h100;
   localparam logic [11:0] LI = 12'h080;
   localparam logic [11:0] EI = 12'h040;
   localparam logic [11:0] LA = 12'h020;
   localparam logic [11:0] EA = 12'h010;
   localparam logic [11:0] SU = 12'h008;
   localparam logic [11:0] EU = 12'h004;
   localparam logic [11:0] LB = 12'h002;
   localparam logic [11:0] LO = 12'h001;
   localparam logic [11:0] NONE = 12'h000;

   localparam logic [5:0] IDLE = 6'b000000;
   localparam logic [5:0] T1 = 6'b000001;
   localparam logic [5:0] T2 = 6'b000010;
   localparam logic [5:0] T3 = 6'b000100;
   localparam logic [5:0] T4 = 6'b001000;
   localparam logic [5:0] T5 = 6'b010000;
   localparam logic [5:0] T6 = 6'b100000;

   logic [11:0] obs_cw;
   logic [4:0]  bus_drv;
   assign obs_cw  = {cp, ep, lm_n, ce_n, li_n, ei, la_n, ea, su, eu, lb_n, lo_n};
   assign bus_drv = {ep, ~ce_n, ei, ea, eu};

   sap_ctrl_seq #(.OPW(4), .NT(6)) dut (
      .clk    (clk),
      .clr    (clr),
      .run    (run),
      .ir_op  (ir_op),
      .cp     (cp),
      .ep     (ep),
      .lm_n   (lm_n),
      .ce_n   (ce_n),
      .li_n   (li_n),
      .ei     (ei),
      .la_n   (la_n),
      .ea     (ea),
      .su     (su),
      .eu     (eu),
      .lb_n   (lb_n),
      .lo_n   (lo_n),
      .tstate (tstate),
      .halted (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // act lists the asserted signals; XOR with INACT yields the pin-level word
   task automatic chk(input string tag, input logic [5:0] et, input logic [11:0] act,
                      input logic eh);
      logic [11:0] ecw;
      ecw = INACT ^ act;
      checks++;
      assert ({tstate, obs_cw, halted} === {et, ecw, eh})
      else begin
         errors++;
         $error("FAIL %s: observed tstate=%b cw=%h halted=%b, expected tstate=%b cw=%h halted=%b",
                tag, tstate, obs_cw, halted, et, ecw, eh);
      end
   endtask

   task automatic excl();
      checks++;
      assert ($countones(bus_drv) <= 1)
      else begin
         errors++;
         $error("FAIL bus_excl: observed drivers=%b state=%b op=%h, expected at most one",
                bus_drv, tstate, ir_op);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      excl();
   endtask

   initial begin
      clr   = 1'b0;
      run   = 1'b1;
      ir_op = 4'h0;

      repeat (3) begin
         tick();
         chk("reset", IDLE, NONE, 1'b0);
      end
      clr = 1'b1;

      // Fetch with garbage opcodes that must not matter
      tick(); chk("f_t1", T1, EP | LM, 1'b0); ir_op = 4'hF;
      tick(); chk("f_t2", T2, CP, 1'b0);      ir_op = 4'hE;
      tick(); chk("f_t3", T3, CE | LI, 1'b0); ir_op = 4'h1; run = 1'b0;

      // ADD, with run dropped: ring keeps going
      tick(); chk("add_t4", T4, EI | LM, 1'b0);
      tick(); chk("add_t5", T5, CE | LB, 1'b0);
      tick(); chk("add_t6", T6, EU | LA, 1'b0);
      tick(); chk("add_t1", T1, EP | LM, 1'b0);

      // SUB
      tick(); chk("sub_t2", T2, CP, 1'b0);
      tick(); chk("sub_t3", T3, CE | LI, 1'b0); ir_op = 4'h2;
      tick(); chk("sub_t4", T4, EI | LM, 1'b0);
      tick(); chk("sub_t5", T5, CE | LB | SU, 1'b0);
      tick(); chk("sub_t6", T6, EU | LA | SU, 1'b0);
      tick(); chk("sub_t1", T1, EP | LM, 1'b0);

      // OUT
      tick(); tick(); ir_op = 4'hE;
      tick(); chk("out_t4", T4, EA | LO, 1'b0);
      tick(); chk("out_t5", T5, NONE, 1'b0);
      tick(); chk("out_t6", T6, NONE, 1'b0);
      tick(); chk("out_t1", T1, EP | LM, 1'b0);

      // NOP opcode
      tick(); tick(); ir_op = 4'h5;
      tick(); chk("nop_t4", T4, NONE, 1'b0);
      tick(); chk("nop_t5", T5, NONE, 1'b0);
      tick(); chk("nop_t6", T6, NONE, 1'b0);
      tick(); chk("nop_t1", T1, EP | LM, 1'b0);

      // LDA interrupted by asynchronous reset in T5
      tick(); tick(); ir_op = 4'h0;
      tick(); chk("lda_t4", T4, EI | LM, 1'b0);
      tick(); chk("lda_t5", T5, CE | LA, 1'b0);
      #2 clr = 1'b0;
      #1 chk("rst_async", IDLE, NONE, 1'b0);
      tick(); chk("rst_hold", IDLE, NONE, 1'b0);
      clr = 1'b1; run = 1'b1;
      tick(); chk("restart_t1", T1, EP | LM, 1'b0);

      // HLT: park in HALT while run toggles
      tick(); tick(); ir_op = 4'hF;
      tick(); chk("hlt_t4", T4, NONE, 1'b0);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("halt_hold", IDLE, NONE, 1'b1);
         run = (i % 2 == 0);
      end
      clr = 1'b0;
      #1 chk("halt_clr", IDLE, NONE, 1'b0);
      tick();
      clr = 1'b1; run = 1'b0;
      tick(); chk("idle_norun", IDLE, NONE, 1'b0);
      run = 1'b1;
      tick(); chk("rerun_t1", T1, EP | LM, 1'b0);

      // Sweep all opcodes; exclusivity is checked on every tick
      for (int op = 0; op < 16; op++) begin
         tick(); tick();
         ir_op = 4'(op);
         tick();
         if (op == 15) begin
            tick(); chk("sweep_halt", IDLE, NONE, 1'b1);
         end else begin
            tick(); tick(); tick();
            chk("sweep_t1", T1, EP | LM, 1'b0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
